// File: rtl/cp0_multi_issue.sv
// rtl/cp0_multi_issue.sv - N-slot in-order coprocessor-0 (BadVAddr, Count, Compare, Status, Cause, EPC)
//
// Resolves exceptions, ERETs and MTC0 writes arriving on ISSUE_W commit slots
// in program order (slot 0 oldest), produces the registered interrupt request
// and the fetch redirect.
//
// Optional build macro: CP0_PRID_CONFIG_EN adds read-only PRId (15) and Config (16).
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   hw_int            level-sensitive external interrupts -> Cause.IP[7:2]
//   wr_en/addr/data   per-slot MTC0 commit
//   rd_addr/rd_data   per-slot MFC0 (combinational, pre-write value)
//   exc_valid/code/bd/pc/badva  per-slot exception commit
//   eret              per-slot ERET commit
//   int_req           registered interrupt request
//   redirect(_pc)     one-cycle flush pulse and target
//   kill_mask         slots younger than the resolved event
//   exl_o, epc_o      Status.EXL and EPC mirrors
module cp0_multi_issue #(
  parameter int          ISSUE_W      = 2,
  parameter int          HW_INT_W     = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HW_INT_W-1:0]   hw_int,
  input  logic [ISSUE_W-1:0]    wr_en,
  input  logic [5*ISSUE_W-1:0]  wr_addr,
  input  logic [32*ISSUE_W-1:0] wr_data,
  input  logic [5*ISSUE_W-1:0]  rd_addr,
  output logic [32*ISSUE_W-1:0] rd_data,
  input  logic [ISSUE_W-1:0]    exc_valid,
  input  logic [5*ISSUE_W-1:0]  exc_code,
  input  logic [ISSUE_W-1:0]    exc_bd,
  input  logic [32*ISSUE_W-1:0] exc_pc,
  input  logic [32*ISSUE_W-1:0] exc_badva,
  input  logic [ISSUE_W-1:0]    eret,
  output logic                  int_req,
  output logic                  redirect,
  output logic [31:0]           redirect_pc,
  output logic [ISSUE_W-1:0]    kill_mask,
  output logic                  exl_o,
  output logic [31:0]           epc_o
);

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  // IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] PRID_VAL     = 32'h0001_8000;
  localparam logic [31:0] CONFIG_VAL   = {1'b1, 15'd0, 1'b0, 2'd0, 3'd0, 3'd0, 4'd0, 3'd2};

  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] badva_q,    badva_d;
  logic [31:0] status_q,   status_d;
  logic [31:0] epc_q,      epc_d;
  logic        div_q,      div_d;
  logic        bd_q,       bd_d;
  logic        ti_q,       ti_d;
  logic [7:0]  ip_q,       ip_d;
  logic [4:0]  exccode_q,  exccode_d;
  logic        int_req_q,  int_req_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] cause_rd;
  logic [5:0]  hw6;

  // Event resolution results
  logic               ev_found, ev_exc, ev_eret, ev_bd;
  logic [4:0]         ev_code;
  logic [31:0]        ev_pc, ev_badva;
  logic [ISSUE_W-1:0] wr_keep;

  assign cause_rd = {bd_q, ti_q, 14'd0, ip_q, 1'b0, exccode_q, 2'b00};

  // Map however many hardware lines exist onto IP[7:2].
  always_comb begin
    hw6 = '0;
    for (int i = 0; i < 6; i++) begin
      if (i < HW_INT_W) hw6[i] = hw_int[i];
    end
  end

  // First slot with an event wins; everything after it is killed, and the
  // event slot's own MTC0 is dropped along with the younger ones.
  always_comb begin
    ev_found  = 1'b0;
    ev_exc    = 1'b0;
    ev_eret   = 1'b0;
    ev_bd     = 1'b0;
    ev_code   = '0;
    ev_pc     = '0;
    ev_badva  = '0;
    wr_keep   = '0;
    kill_mask = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      kill_mask[i] = ev_found;
      wr_keep[i]   = wr_en[i] & ~ev_found & ~(exc_valid[i] | eret[i]);
      if (!ev_found && (exc_valid[i] || eret[i])) begin
        ev_found = 1'b1;
        ev_exc   = exc_valid[i];
        ev_eret  = ~exc_valid[i];
        ev_bd    = exc_bd[i];
        ev_code  = exc_code[5*i +: 5];
        ev_pc    = exc_pc[32*i +: 32];
        ev_badva = exc_badva[32*i +: 32];
      end
    end
  end

  always_comb begin
    logic       tick;
    logic       cmp_wr;
    logic [1:0] ip_sw;

    tick          = (COUNT_DIV <= 1) ? 1'b1 : div_q;
    div_d         = tick ? 1'b0 : ~div_q;
    count_d       = count_q + {31'd0, tick};
    compare_d     = compare_q;
    badva_d       = badva_q;
    status_d      = status_q;
    epc_d         = epc_q;
    bd_d          = bd_q;
    exccode_d     = exccode_q;
    ip_sw         = ip_q[1:0];
    cmp_wr        = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    // Ascending order so the youngest surviving write to a register wins.
    for (int i = 0; i < ISSUE_W; i++) begin
      if (wr_keep[i]) begin
        case (wr_addr[5*i +: 5])
          5'd9: begin
            count_d = wr_data[32*i +: 32];
            div_d   = 1'b0;
          end
          5'd11: begin
            compare_d = wr_data[32*i +: 32];
            cmp_wr    = 1'b1;
          end
          5'd12: status_d = (status_q & ~STATUS_WMASK) | (wr_data[32*i +: 32] & STATUS_WMASK);
          5'd13: ip_sw    = wr_data[32*i+8 +: 2];
          5'd14: epc_d    = wr_data[32*i +: 32];
          default: ;
        endcase
      end
    end

    ti_d = cmp_wr ? 1'b0 : (ti_q | (count_q == compare_q));
    ip_d = {hw6[5] | ti_d, hw6[4:0], ip_sw};

    // Exception/ERET field updates are applied last so they override MTC0.
    if (ev_exc) begin
      exccode_d   = ev_code;
      status_d[1] = 1'b1;
      if (!status_q[1]) begin
        epc_d = ev_bd ? (ev_pc - 32'd4) : ev_pc;
        bd_d  = ev_bd;
      end
      if (ev_code == 5'd4 || ev_code == 5'd5) badva_d = ev_badva;
      redirect_d    = 1'b1;
      redirect_pc_d = EXC_VECTOR;
    end else if (ev_eret) begin
      status_d[1]   = 1'b0;
      redirect_d    = 1'b1;
      redirect_pc_d = epc_q;
    end

    int_req_d = status_q[0] & ~status_q[1] & (|(ip_q & status_q[15:8]));
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      case (rd_addr[5*i +: 5])
        5'd8:  rd_data[32*i +: 32] = badva_q;
        5'd9:  rd_data[32*i +: 32] = count_q;
        5'd11: rd_data[32*i +: 32] = compare_q;
        5'd12: rd_data[32*i +: 32] = status_q;
        5'd13: rd_data[32*i +: 32] = cause_rd;
        5'd14: rd_data[32*i +: 32] = epc_q;
`ifdef CP0_PRID_CONFIG_EN
        5'd15: rd_data[32*i +: 32] = PRID_VAL;
        5'd16: rd_data[32*i +: 32] = CONFIG_VAL;
`endif
        default: rd_data[32*i +: 32] = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q       <= '0;
      compare_q     <= '0;
      badva_q       <= '0;
      status_q      <= RESET_STATUS;
      epc_q         <= '0;
      div_q         <= 1'b0;
      bd_q          <= 1'b0;
      ti_q          <= 1'b0;
      ip_q          <= '0;
      exccode_q     <= '0;
      int_req_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      count_q       <= count_d;
      compare_q     <= compare_d;
      badva_q       <= badva_d;
      status_q      <= status_d;
      epc_q         <= epc_d;
      div_q         <= div_d;
      bd_q          <= bd_d;
      ti_q          <= ti_d;
      ip_q          <= ip_d;
      exccode_q     <= exccode_d;
      int_req_q     <= int_req_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign int_req     = int_req_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign exl_o       = status_q[1];
  assign epc_o       = epc_q;

endmodule
